fetch_queue: RTL and testbench
==============================

# fetch_queue

Parametrised fetch stage with a prefetch queue. It generates the PC and issues one instruction-memory read per cycle while queue credit remains. Returned words are buffered in a DEPTH-entry FIFO and presented to decode over a valid/ready handshake. It sits between instruction memory and pipeline register 1, accepting prioritised redirects and multi-cycle IR injection.

## Interface
- XLEN, 16, instruction and PC width
- DEPTH, 4, queue entries; power of two, at least 2
- NREDIR, 6, redirect sources; index 0 has highest priority
- RESET_PC, 0, PC value loaded at reset
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- redir_valid  in  NREDIR  per-source redirect request
- redir_target  in  NREDIR*XLEN  targets; source i occupies bits [i*XLEN +: XLEN]
- imem_req  out  1  read strobe
- imem_addr  out  XLEN  read address
- imem_rdata  in  XLEN  read data, fixed 1-cycle latency after imem_req
- inj_valid  in  1  multi-cycle IR override active
- inj_ir  in  XLEN  injected instruction
- out_valid  out  1  head entry (or injection) valid
- out_ready  in  1  decode accepts
- out_ir  out  XLEN  instruction to decode
- out_pc  out  XLEN  PC of out_ir
- out_pc_inc  out  XLEN  out_pc + 1, modulo 2^XLEN

## Operation
- State: pc, fifo (ir, pc per entry), count (0..DEPTH), inflight (0/1), epoch (1 bit), inflight_epoch.
- Credit: issue when count + inflight - pop < DEPTH. imem_req = credit or redirect. imem_addr = redirect target if any redir_valid, else pc.
- On issue: pc <= imem_addr + 1; inflight <= 1; the request's pc and epoch are tagged.
- Response: the cycle after issue, imem_rdata is pushed with its tagged pc only if the tag epoch equals the current epoch. Stale data is dropped.
- Redirect (any redir_valid): the lowest set index wins. Flush fifo (count <= 0), toggle epoch, issue at the target the same cycle. Redirect beats simultaneous push and pop.
- Pop: out_valid & out_ready & ~inj_valid.
- Injection: while inj_valid, out_valid = 1, out_ir = inj_ir, out_pc = head pc, and the head is held (no pop). Fetch continues until credit is exhausted.
- Otherwise out_valid = (count != 0); out_ir and out_pc come from the head entry. When invalid they are 0.
- PC arithmetic wraps modulo 2^XLEN (0xFFFF + 1 = 0x0000).
- Full: no issue. Push is impossible when full by credit construction.
- Empty: out_valid = 0 unless inj_valid, or unless bypass (see Configuration).

## Timing
- Reset values: pc = RESET_PC, count = 0, inflight = 0, epoch = 0, imem_req = 0, out_valid = 0, out_ir/out_pc = 0, out_pc_inc = 1.
- First imem_req with addr = RESET_PC occurs in the first cycle after reset deasserts.
- Fetch-to-decode latency: issue at t, data at t+1, out_valid at t+2 (t+1 with bypass).
- Redirect at t: imem_addr = target at t, and the target instruction is valid at t+2.
- Reset asserted mid-operation clears all state immediately. In-flight data returned after reset deassertion is dropped via inflight = 0.
- Steady state: one instruction per cycle with DEPTH at least 2 and out_ready held high.

## Configuration
- FETCH_QUEUE_BYPASS_EN defined: when count = 0 and a current-epoch response arrives, the response drives out_ir/out_pc/out_valid combinationally that same cycle. If popped, it is not written to the fifo.
- Undefined: every response is written to the fifo first, so the minimum latency is 2 cycles.

## Structure
- Shared package fetch_pkg: default XLEN, RESET_PC constant, and the fifo entry struct (ir, pc).
- One sub-module, fetch_fifo: a parametrised synchronous FIFO (DEPTH, entry width) with push, pop, flush, count, and head outputs.
- Priority redirect selection is implemented inline as a for-loop priority mux.

## Test plan
- Reset release, out_ready = 1, imem returns addr + 0x100: PCs 0,1,2,… issued one per cycle; out_ir 0x100 at t+2, then one per cycle.
- out_ready = 0 for 10 cycles with DEPTH = 4: exactly 4 requests issued, then imem_req = 0. Releasing out_ready delivers PCs 0–3 in order with no loss.
- redir_valid = 6'b001010, targets[1] = 0x40, targets[3] = 0x80, while the queue holds 3 entries: flush, imem_addr = 0x40. The stale response is dropped, and the next out_pc = 0x40.
- RESET_PC = 0xFFFE: PCs 0xFFFE, 0xFFFF, 0x0000 issued, and out_pc_inc at 0xFFFF reads 0x0000.
- inj_valid held 3 cycles with inj_ir = 0xA5A5 and head pc = 5: out_ir = 0xA5A5 and out_pc = 5 for 3 cycles. After release, head ir/pc = 5 is presented.
- Reset pulsed while inflight = 1: outputs return to reset values, and the first post-reset out_pc = RESET_PC.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared fetch-stage types and defaults: widths, reset PC and the prefetch entry layout.
package fetch_pkg;

  localparam int XLEN_DEF   = 16;
  localparam int DEPTH_DEF  = 4;
  localparam int NREDIR_DEF = 6;

  localparam logic [XLEN_DEF-1:0] RESET_PC_DEF = '0;

  typedef struct packed {
    logic [XLEN_DEF-1:0] ir;
    logic [XLEN_DEF-1:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO: power-of-two ring buffer with push, pop, flush, occupancy and head.
module fetch_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 32
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic                   flush_i,
  input  logic [W-1:0]           din_i,
  output logic [$clog2(DEPTH):0] count_o,
  output logic [W-1:0]           head_o
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] rd_q, wr_q;
  logic [AW:0]   cnt_q;
  logic          do_push, do_pop;

  assign do_push = push_i & (cnt_q != (AW+1)'(DEPTH));
  assign do_pop  = pop_i  & (cnt_q != '0);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else if (flush_i) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + AW'(1);
      if (do_pop)  rd_q <= rd_q + AW'(1);
      cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  // Storage needs no reset: occupancy alone qualifies the head.
  always_ff @(posedge clk_i) begin
    if (do_push && !flush_i) mem_q[wr_q] <= din_i;
  end

  assign count_o = cnt_q;
  assign head_o  = mem_q[rd_q];

endmodule

// File: rtl/fetch_queue.sv
// Fetch stage with prefetch queue, prioritised redirects and IR injection.
// Optional macro FETCH_QUEUE_BYPASS_EN: forward a response straight to decode when the queue is empty.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int              XLEN     = XLEN_DEF,
  parameter int              DEPTH    = DEPTH_DEF,
  parameter int              NREDIR   = NREDIR_DEF,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEF)
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [NREDIR-1:0]      redir_valid_i,
  input  logic [NREDIR*XLEN-1:0] redir_target_i,
  output logic                   imem_req_o,
  output logic [XLEN-1:0]        imem_addr_o,
  input  logic [XLEN-1:0]        imem_rdata_i,
  input  logic                   inj_valid_i,
  input  logic [XLEN-1:0]        inj_ir_i,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic [XLEN-1:0]        out_ir_o,
  output logic [XLEN-1:0]        out_pc_o,
  output logic [XLEN-1:0]        out_pc_inc_o
);

  localparam int CW = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [XLEN-1:0] ir;
    logic [XLEN-1:0] pc;
  } entry_t;

  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] infl_pc_q, infl_pc_d;
  logic            inflight_q, inflight_d;
  logic            epoch_q, epoch_d;
  logic            infl_epoch_q, infl_epoch_d;

  logic            redir_any;
  logic [XLEN-1:0] redir_tgt;
  logic            resp_ok, byp, byp_take;
  logic            head_vld, pop, fifo_pop, push, credit, issue;
  logic [CW-1:0]   fifo_cnt;
  logic [CW:0]     occ;
  entry_t          fifo_head, head, resp_e;

  // Lowest index wins: scan from the top so later hits override.
  always_comb begin
    redir_tgt = '0;
    for (int i = NREDIR - 1; i >= 0; i--) begin
      if (redir_valid_i[i]) redir_tgt = redir_target_i[i*XLEN +: XLEN];
    end
  end

  assign redir_any = |redir_valid_i;
  assign resp_ok   = inflight_q & (infl_epoch_q == epoch_q);
  assign resp_e    = '{ir: imem_rdata_i, pc: infl_pc_q};

`ifdef FETCH_QUEUE_BYPASS_EN
  assign byp  = (fifo_cnt == '0) & resp_ok;
  assign head = byp ? resp_e : fifo_head;
`else
  assign byp  = 1'b0;
  assign head = fifo_head;
`endif

  assign head_vld     = (fifo_cnt != '0) | byp;
  assign out_valid_o  = inj_valid_i | head_vld;
  assign out_ir_o     = inj_valid_i ? inj_ir_i : (head_vld ? head.ir : '0);
  assign out_pc_o     = head_vld ? head.pc : '0;
  assign out_pc_inc_o = out_pc_o + XLEN'(1);

  assign pop      = out_valid_o & out_ready_i & ~inj_valid_i;
  assign fifo_pop = pop & (fifo_cnt != '0);
  assign byp_take = pop & byp & (fifo_cnt == '0);

  // Credit counts the in-flight word so a response always finds a free slot.
  assign occ    = {1'b0, fifo_cnt} + (CW+1)'(inflight_q) - (CW+1)'(pop);
  assign credit = occ < (CW+1)'(DEPTH);
  assign issue  = (credit | redir_any) & rst_ni;

  assign imem_req_o  = issue;
  assign imem_addr_o = redir_any ? redir_tgt : pc_q;

  assign push = resp_ok & ~redir_any & ~byp_take;

  always_comb begin
    pc_d         = issue ? imem_addr_o + XLEN'(1) : pc_q;
    inflight_d   = issue;
    infl_pc_d    = imem_addr_o;
    epoch_d      = epoch_q ^ redir_any;
    infl_epoch_d = epoch_q ^ redir_any;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pc_q         <= RESET_PC;
      infl_pc_q    <= '0;
      inflight_q   <= 1'b0;
      epoch_q      <= 1'b0;
      infl_epoch_q <= 1'b0;
    end else begin
      pc_q         <= pc_d;
      infl_pc_q    <= infl_pc_d;
      inflight_q   <= inflight_d;
      epoch_q      <= epoch_d;
      infl_epoch_q <= infl_epoch_d;
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .W     ($bits(entry_t))
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (push),
    .pop_i   (fifo_pop),
    .flush_i (redir_any),
    .din_i   (resp_e),
    .count_o (fifo_cnt),
    .head_o  (fifo_head)
  );

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: queue-based reference model checked every cycle, plus directed literal pins.
module tb_fetch_queue;
  import fetch_pkg::*;

  localparam int          DEPTH  = 4;
  localparam logic [15:0] RST_PC = 16'h0000;
`ifdef FETCH_QUEUE_BYPASS_EN
  localparam int BYP = 1;
`else
  localparam int BYP = 0;
`endif
  localparam int LAT = 2 - BYP;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [5:0]  redir_valid;
  logic [95:0] redir_target;
  logic        imem_req;
  logic [15:0] imem_addr, imem_rdata;
  logic        inj_valid;
  logic [15:0] inj_ir;
  logic        out_valid, out_ready;
  logic [15:0] out_ir, out_pc, out_pc_inc;

  fetch_queue #(.XLEN(16), .DEPTH(DEPTH), .NREDIR(6), .RESET_PC(RST_PC)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .redir_valid_i(redir_valid), .redir_target_i(redir_target),
    .imem_req_o(imem_req), .imem_addr_o(imem_addr), .imem_rdata_i(imem_rdata),
    .inj_valid_i(inj_valid), .inj_ir_i(inj_ir),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .out_ir_o(out_ir), .out_pc_o(out_pc), .out_pc_inc_o(out_pc_inc)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // Reference state: next fetch PC, the queue of delivered-but-unconsumed words, one outstanding read.
  logic [15:0]  m_pc;
  fetch_entry_t m_q[$];
  bit           m_infl;
  logic [15:0]  m_infl_pc;

  logic        d_req, d_ov;
  logic [15:0] d_addr, d_ir, d_pc, d_inc;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc = RST_PC;
    m_q.delete();
    m_infl = 0;
    m_infl_pc = '0;
  endtask

  task automatic cycle();
    logic [15:0]  tgt, e_addr, e_ir, e_pc, nxt;
    bit           rany, hv, byp, e_ov, pop, credit, e_req, took;
    int           sz;
    fetch_entry_t hd, rsp;
    @(negedge clk);
    d_req = imem_req; d_addr = imem_addr; d_ov = out_valid;
    d_ir = out_ir; d_pc = out_pc; d_inc = out_pc_inc;
    if (!rst_n) begin
      model_reset();
      chk("rst_req", d_req, 0);
      chk("rst_ovalid", d_ov, 0);
      chk("rst_ir", d_ir, 0);
      chk("rst_pc", d_pc, 0);
      chk("rst_pcinc", d_inc, 1);
    end else begin
      rany = 0; tgt = '0;
      for (int i = 0; i < 6; i++)
        if (redir_valid[i] && !rany) begin rany = 1; tgt = redir_target[i*16 +: 16]; end
      sz  = m_q.size();
      rsp.ir = imem_rdata; rsp.pc = m_infl_pc;
      byp = (BYP == 1) && sz == 0 && m_infl;
      hv  = sz > 0 || byp;
      hd  = (sz > 0) ? m_q[0] : rsp;
      e_ov = inj_valid || hv;
      e_ir = inj_valid ? inj_ir : (hv ? hd.ir : 16'h0);
      e_pc = hv ? hd.pc : 16'h0;
      pop  = e_ov && out_ready && !inj_valid;
      credit = (sz + int'(m_infl) - int'(pop)) < DEPTH;
      e_req  = credit || rany;
      e_addr = rany ? tgt : m_pc;
      chk("req", d_req, e_req);
      chk("addr", d_addr, e_addr);
      chk("ovalid", d_ov, e_ov);
      chk("ir", d_ir, e_ir);
      chk("pc", d_pc, e_pc);
      chk("pcinc", d_inc, 16'(e_pc + 16'h1));
      if (rany) m_q.delete();
      else begin
        took = 0;
        if (pop) begin
          if (sz > 0) void'(m_q.pop_front());
          else took = 1;
        end
        if (m_infl && !took) m_q.push_back(rsp);
      end
      if (e_req) m_pc = 16'(e_addr + 16'h1);
      m_infl = e_req;
      m_infl_pc = e_addr;
    end
    nxt = d_req ? 16'(d_addr + 16'h0100) : 16'($urandom);
    @(posedge clk);
    #1;
    imem_rdata = nxt;
  endtask

  task automatic pulse_reset();
    rst_n = 0;
    cycle();
    rst_n = 1;
  endtask

  initial begin
    int nreq;
    rst_n = 0; redir_valid = '0; redir_target = '0; imem_rdata = '0;
    inj_valid = 0; inj_ir = '0; out_ready = 0;
    model_reset();

    // Reset values, then streaming with decode always ready.
    repeat (3) cycle();
    chk("lit_rst_req", d_req, 0);
    chk("lit_rst_pcinc", d_inc, 1);
    rst_n = 1; out_ready = 1;
    cycle();
    chk("lit_first_req", d_req, 1);
    chk("lit_first_addr", d_addr, RST_PC);
    cycle();
    chk("lit_second_addr", d_addr, 16'h0001);
    cycle();
    chk("lit_first_ov", d_ov, 1);
    chk("lit_first_pc", d_pc, 2 - LAT);
    chk("lit_first_ir", d_ir, 16'h0100 + 2 - LAT);
    repeat (5) cycle();
    chk("lit_stream_pc", d_pc, 7 - LAT);

    // Decode stalled: the queue fills to DEPTH and issue stops.
    pulse_reset();
    out_ready = 0; nreq = 0;
    repeat (10) begin cycle(); nreq += int'(d_req); end
    chk("lit_stall_reqs", nreq, DEPTH);
    out_ready = 1;
    cycle();
    chk("lit_release_pc", d_pc, 16'h0000);
    repeat (3) cycle();
    chk("lit_release_pc3", d_pc, 16'h0003);

    // Prioritised redirect while the queue holds three words.
    pulse_reset();
    out_ready = 0;
    repeat (4) cycle();
    redir_valid = 6'b001010;
    redir_target[1*16 +: 16] = 16'h0040;
    redir_target[3*16 +: 16] = 16'h0080;
    cycle();
    chk("lit_redir_addr", d_addr, 16'h0040);
    redir_valid = '0; out_ready = 1;
    cycle();
    chk("lit_redir_flushed", d_ov, BYP);
    cycle();
    chk("lit_redir_pc", d_pc, 16'h0040 + BYP);
    chk("lit_redir_ir", d_ir, 16'h0140 + BYP);

    // PC wrap at the top of the address space.
    redir_valid = 6'b000001; redir_target[15:0] = 16'hFFFE;
    cycle();
    chk("lit_wrap_addr0", d_addr, 16'hFFFE);
    redir_valid = '0;
    cycle();
    chk("lit_wrap_addr1", d_addr, 16'hFFFF);
    cycle();
    chk("lit_wrap_addr2", d_addr, 16'h0000);
    cycle();
    chk("lit_wrap_pc", d_pc, (BYP == 1) ? 16'h0000 : 16'hFFFF);
    chk("lit_wrap_pcinc", d_inc, (BYP == 1) ? 16'h0001 : 16'h0000);

    // Injection holds the head at pc 5 for three cycles.
    out_ready = 0;
    redir_valid = 6'b000001; redir_target[15:0] = 16'h0005;
    cycle();
    redir_valid = '0;
    repeat (2) cycle();
    inj_valid = 1; inj_ir = 16'hA5A5; out_ready = 1;
    repeat (3) begin
      cycle();
      chk("lit_inj_ir", d_ir, 16'hA5A5);
      chk("lit_inj_pc", d_pc, 16'h0005);
    end
    inj_valid = 0;
    cycle();
    chk("lit_post_inj_ir", d_ir, 16'h0105);
    chk("lit_post_inj_pc", d_pc, 16'h0005);

    // Reset landing while a read is outstanding.
    repeat (3) cycle();
    rst_n = 0;
    cycle();
    chk("lit_midrst_ov", d_ov, 0);
    chk("lit_midrst_pcinc", d_inc, 1);
    rst_n = 1;
    repeat (LAT + 1) cycle();
    chk("lit_postrst_ov", d_ov, 1);
    chk("lit_postrst_pc", d_pc, RST_PC);

    // Randomised traffic with rare redirects, injections and resets.
    for (int n = 0; n < 3000; n++) begin
      rst_n        = ($urandom_range(0, 299) != 0);
      out_ready    = ($urandom_range(0, 9) < 7);
      inj_valid    = rst_n && ($urandom_range(0, 9) == 0);
      inj_ir       = 16'($urandom);
      redir_valid  = ($urandom_range(0, 19) == 0) ? 6'($urandom_range(1, 63)) : 6'b0;
      redir_target = {$urandom, $urandom, $urandom};
      cycle();
    end
    rst_n = 1; redir_valid = '0; inj_valid = 0;
    repeat (5) cycle();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
